// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  // Wait-state counter width; WAIT_N is limited to 0..15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-input round-robin pick: on a tie, the side that was not granted last wins.
module mem_port_arbiter_rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,   // bit 0 = CPU, bit 1 = loader
  input  logic       last_i,  // owner code of the last completed grant
  output logic       valid_o,
  output logic       pick_o   // owner code of the winner
);

  // Tie goes to the opposite of the last grant; otherwise the lone requester.
  always_comb begin
    valid_o = |req_i;
    if (&req_i) begin
      pick_o = ~last_i;
    end else begin
      pick_o = req_i[1] ? OWN_LDR : OWN_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the CPU and the loader/debug requester.
// Registered memory-side outputs, one access per grant, WAIT_N extra strobe cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned WAIT_N = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_WDATA,
  output logic [DW-1:0] CPU_RDATA,
  output logic          CPU_ACK,
  input  logic          LDR_REQ,
  input  logic          LDR_WE,
  input  logic [AW-1:0] LDR_ADDR,
  input  logic [DW-1:0] LDR_WDATA,
  output logic [DW-1:0] LDR_RDATA,
  output logic          LDR_ACK,
  output logic [AW-1:0] MADDR,
  output logic [DW-1:0] MDATA_O,
  input  logic [DW-1:0] MDATA_I,
  output logic          RD,
  output logic          WR,
  output logic          OWNER
);

  localparam logic [CNT_W-1:0] WaitInit = CNT_W'(WAIT_N);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    maddr_q, maddr_d;
  logic [DW-1:0]    mdata_q, mdata_d;
  logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]    ldr_rdata_q, ldr_rdata_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             cpu_ack_q, cpu_ack_d;
  logic             ldr_ack_q, ldr_ack_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;

  logic             grant_valid;
  logic             grant_pick;
  logic             win_we;

  mem_port_arbiter_rr_pick2 u_rr_pick2 (
    .req_i   ({LDR_REQ, CPU_REQ}),
    .last_i  (last_q),
    .valid_o (grant_valid),
    .pick_o  (grant_pick)
  );

  assign win_we = (grant_pick == OWN_LDR) ? LDR_WE : CPU_WE;

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      maddr_q     <= '0;
      mdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_LDR;  // CPU wins the first tie
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      maddr_q     <= maddr_d;
      mdata_q     <= mdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
    end
  end

  // Next-state: IDLE -> ACCESS on any request, ACCESS -> DONE when waits expire.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_valid) state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: latch winner in IDLE, complete in ACCESS, turnaround in DONE.
  always_comb begin
    cnt_d       = cnt_q;
    maddr_d     = maddr_q;
    mdata_d     = mdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    owner_d     = owner_q;
    last_d      = last_q;
    case (state_q)
      ST_IDLE: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        if (grant_valid) begin
          owner_d = grant_pick;
          maddr_d = (grant_pick == OWN_LDR) ? LDR_ADDR : CPU_ADDR;
          mdata_d = (grant_pick == OWN_LDR) ? LDR_WDATA : CPU_WDATA;
          rd_d    = ~win_we;
          wr_d    = win_we;
          cnt_d   = WaitInit;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (owner_q == OWN_LDR) begin
            ldr_ack_d = 1'b1;
            if (rd_q) ldr_rdata_d = MDATA_I;
          end else begin
            cpu_ack_d = 1'b1;
            if (rd_q) cpu_rdata_d = MDATA_I;
          end
        end
      end
      ST_DONE: begin
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        last_d = owner_q;
      end
      default: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
      end
    endcase
  end

  assign MADDR     = maddr_q;
  assign MDATA_O   = mdata_q;
  assign RD        = rd_q;
  assign WR        = wr_q;
  assign CPU_ACK   = cpu_ack_q;
  assign LDR_ACK   = ldr_ack_q;
  assign CPU_RDATA = cpu_rdata_q;
  assign LDR_RDATA = ldr_rdata_q;
  assign OWNER     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized transactions against a
// transaction-level round-robin model.
module tb_mem_port_arbiter;

  localparam int unsigned W = 1;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       CPU_REQ, CPU_WE, LDR_REQ, LDR_WE;
  logic [7:0] CPU_ADDR, CPU_WDATA, LDR_ADDR, LDR_WDATA;
  logic [7:0] CPU_RDATA, LDR_RDATA, MADDR, MDATA_O, MDATA_I;
  logic       CPU_ACK, LDR_ACK, RD, WR, OWNER;

  logic [7:0] mem [256];
  assign MDATA_I = mem[MADDR];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(
    .AW     (8),
    .DW     (8),
    .WAIT_N (W)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CPU_REQ   (CPU_REQ),
    .CPU_WE    (CPU_WE),
    .CPU_ADDR  (CPU_ADDR),
    .CPU_WDATA (CPU_WDATA),
    .CPU_RDATA (CPU_RDATA),
    .CPU_ACK   (CPU_ACK),
    .LDR_REQ   (LDR_REQ),
    .LDR_WE    (LDR_WE),
    .LDR_ADDR  (LDR_ADDR),
    .LDR_WDATA (LDR_WDATA),
    .LDR_RDATA (LDR_RDATA),
    .LDR_ACK   (LDR_ACK),
    .MADDR     (MADDR),
    .MDATA_O   (MDATA_O),
    .MDATA_I   (MDATA_I),
    .RD        (RD),
    .WR        (WR),
    .OWNER     (OWNER)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Watchdog: the stimulus is a fixed schedule, so this only trips on a simulator stall.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  // Model state
  logic       cpu_pend, ldr_pend, cpu_we_m, ldr_we_m;
  logic [7:0] cpu_addr_m, ldr_addr_m, cpu_wd_m, ldr_wd_m;
  logic [7:0] cpu_rd_m, ldr_rd_m;
  logic       last_m, owner_m, win, win_we;
  logic [7:0] win_addr, win_wd;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hA5;

    // Reset with both sides requesting
    RST_N = 1'b0;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 8'h10; CPU_WDATA = 8'h00;
    LDR_REQ = 1'b1; LDR_WE = 1'b1; LDR_ADDR = 8'h3F; LDR_WDATA = 8'h5A;
    tick(); tick();
    check("rst_rd", RD, 0);
    check("rst_wr", WR, 0);
    check("rst_cpu_ack", CPU_ACK, 0);
    check("rst_ldr_ack", LDR_ACK, 0);
    check("rst_maddr", MADDR, 0);
    check("rst_mdata_o", MDATA_O, 0);
    check("rst_cpu_rdata", CPU_RDATA, 0);
    check("rst_ldr_rdata", LDR_RDATA, 0);
    check("rst_owner", OWNER, 0);
    RST_N = 1'b1;

    // First grant: CPU read of 0x10
    tick();
    check("g1_owner", OWNER, 0);
    check("g1_rd", RD, 1);
    check("g1_wr", WR, 0);
    check("g1_maddr", MADDR, 8'h10);
    // Change address and drop request mid-access
    CPU_ADDR = 8'h20; CPU_REQ = 1'b0;
    tick();
    check("g1_rd_held", RD, 1);
    check("g1_maddr_held", MADDR, 8'h10);
    check("g1_ack_early", CPU_ACK, 0);
    tick();
    check("g1_cpu_ack", CPU_ACK, 1);
    check("g1_ldr_ack", LDR_ACK, 0);
    check("g1_cpu_rdata", CPU_RDATA, 8'hA5);
    check("g1_rd_off", RD, 0);
    check("g1_wr_never", WR, 0);
    tick();
    check("g1_ack_pulse", CPU_ACK, 0);

    // Loader write granted next
    tick();
    check("g2_owner", OWNER, 1);
    check("g2_wr", WR, 1);
    check("g2_rd", RD, 0);
    check("g2_maddr", MADDR, 8'h3F);
    check("g2_mdata_o", MDATA_O, 8'h5A);
    tick();
    check("g2_wr_held", WR, 1);
    tick();
    check("g2_ldr_ack", LDR_ACK, 1);
    check("g2_cpu_ack", CPU_ACK, 0);
    check("g2_cpu_rdata_kept", CPU_RDATA, 8'hA5);
    check("g2_ldr_rdata_kept", LDR_RDATA, 8'h00);
    LDR_REQ = 1'b0;
    tick();  // DONE -> IDLE

    // Randomized transactions against the model
    cpu_pend = 1'b0; ldr_pend = 1'b0;
    cpu_we_m = 1'b0; ldr_we_m = 1'b0;
    cpu_addr_m = '0; ldr_addr_m = '0; cpu_wd_m = '0; ldr_wd_m = '0;
    cpu_rd_m = 8'hA5; ldr_rd_m = 8'h00;
    last_m = 1'b1; owner_m = 1'b1;
    for (int it = 0; it < 60; it++) begin
      if (!cpu_pend && ($urandom_range(2) != 0)) begin
        cpu_pend = 1'b1; cpu_we_m = 1'($urandom);
        cpu_addr_m = 8'($urandom); cpu_wd_m = 8'($urandom);
      end
      if (!ldr_pend && ($urandom_range(2) != 0)) begin
        ldr_pend = 1'b1; ldr_we_m = 1'($urandom);
        ldr_addr_m = 8'($urandom); ldr_wd_m = 8'($urandom);
      end
      CPU_REQ = cpu_pend; CPU_WE = cpu_we_m; CPU_ADDR = cpu_addr_m; CPU_WDATA = cpu_wd_m;
      LDR_REQ = ldr_pend; LDR_WE = ldr_we_m; LDR_ADDR = ldr_addr_m; LDR_WDATA = ldr_wd_m;
      tick();
      if (!cpu_pend && !ldr_pend) begin
        check("idle_rd", RD, 0);
        check("idle_wr", WR, 0);
        check("idle_owner", OWNER, owner_m);
        continue;
      end
      win      = (cpu_pend && ldr_pend) ? ~last_m : ldr_pend;
      win_we   = win ? ldr_we_m : cpu_we_m;
      win_addr = win ? ldr_addr_m : cpu_addr_m;
      win_wd   = win ? ldr_wd_m : cpu_wd_m;
      owner_m  = win;
      check("r_owner", OWNER, win);
      check("r_rd", RD, !win_we);
      check("r_wr", WR, win_we);
      check("r_maddr", MADDR, win_addr);
      if (win_we) check("r_mdata_o", MDATA_O, win_wd);
      // Disturb the winner's inputs; the latched access must not change
      if (win) begin
        LDR_ADDR = 8'($urandom); LDR_WDATA = 8'($urandom); LDR_WE = 1'($urandom);
        LDR_REQ = 1'($urandom);
      end else begin
        CPU_ADDR = 8'($urandom); CPU_WDATA = 8'($urandom); CPU_WE = 1'($urandom);
        CPU_REQ = 1'($urandom);
      end
      for (int k = 0; k < int'(W); k++) begin
        tick();
        check("r_strobe_held", {RD, WR}, {!win_we, win_we});
        check("r_maddr_held", MADDR, win_addr);
        check("r_no_ack", {CPU_ACK, LDR_ACK}, 2'b00);
      end
      tick();
      if (!win_we) begin
        if (win) ldr_rd_m = mem[win_addr];
        else     cpu_rd_m = mem[win_addr];
      end
      check("r_acks", {LDR_ACK, CPU_ACK}, win ? 2'b10 : 2'b01);
      check("r_strobes_off", {RD, WR}, 2'b00);
      check("r_cpu_rdata", CPU_RDATA, cpu_rd_m);
      check("r_ldr_rdata", LDR_RDATA, ldr_rd_m);
      if (win) begin ldr_pend = 1'b0; LDR_REQ = 1'b0; end
      else     begin cpu_pend = 1'b0; CPU_REQ = 1'b0; end
      tick();
      check("r_done_acks", {LDR_ACK, CPU_ACK}, 2'b00);
      check("r_done_strobes", {RD, WR}, 2'b00);
      last_m = win;
    end

    // Reset during ACCESS aborts the access
    CPU_REQ = 1'b0; LDR_REQ = 1'b0;
    tick(); tick();
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 8'h10;
    tick();
    check("ra_rd_before", RD, 1);
    CPU_REQ = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    check("ra_rd_async", RD, 0);
    check("ra_wr_async", WR, 0);
    tick(); tick();
    check("ra_no_ack", {CPU_ACK, LDR_ACK}, 2'b00);
    RST_N = 1'b1;
    tick();
    check("ra_idle_rd", RD, 0);
    check("ra_idle_ack", {CPU_ACK, LDR_ACK}, 2'b00);
    LDR_REQ = 1'b1; LDR_WE = 1'b1; LDR_ADDR = 8'h77; LDR_WDATA = 8'h11;
    tick();
    check("ra_regrant_wr", WR, 1);
    check("ra_regrant_owner", OWNER, 1);
    check("ra_regrant_maddr", MADDR, 8'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
